// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo stream player: FSM state encoding,
// disparity width derivation and checksum width.
package stereo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK,
    S_DONE
  } state_t;

  localparam int DISP_RANGE = 64;
  localparam int CS_W       = 32;

  function automatic int disp_bits(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  localparam int DBIT_DEF = disp_bits(DISP_RANGE);

endpackage

// File: rtl/stereo_stream_capture.sv
// Disparity capture: sample counter plus rotate-xor checksum (checksum built only with
// STEREO_PLAYER_CHECKSUM_EN); results update 1 cycle after i_disp_dval, never stalls the matcher.
module stereo_stream_capture
  import stereo_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic [DBIT-1:0] i_disp,
  input  logic            i_disp_dval,
  output logic [31:0]     o_out_cnt,
  output logic [CS_W-1:0] o_checksum
);

  logic [31:0] r_out_cnt;

  // Clear has priority so a sample coincident with a new run start is dropped
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_out_cnt <= '0;
    end else if (i_disp_dval) begin
      r_out_cnt <= r_out_cnt + 32'd1;
    end
  end

  assign o_out_cnt = r_out_cnt;

`ifdef STEREO_PLAYER_CHECKSUM_EN
  logic [CS_W-1:0] r_cs;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cs <= '0;
    end else if (i_disp_dval) begin
      r_cs <= {r_cs[CS_W-2:0], r_cs[CS_W-1]} ^ {{(CS_W-DBIT){1'b0}}, i_disp};
    end
  end

  assign o_checksum = r_cs;
`else
  logic w_unused_disp;
  assign w_unused_disp = ^i_disp;
  assign o_checksum    = '0;
`endif

endmodule

// File: rtl/stereo_stream_player.sv
// Raster-timed L/R pixel replay with h/v blanking and frame count, plus disparity capture
// (checksum option STEREO_PLAYER_CHECKSUM_EN); stream registered 1 cycle, ready from state only.
module stereo_stream_player
  import stereo_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 450,
  parameter int ROWS = 375,
  parameter int DBIT = DBIT_DEF,
  parameter int BW   = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [BW-1:0]   i_hblank,
  input  logic [BW-1:0]   i_vblank,
  input  logic [7:0]      i_nframes,
  input  logic            i_src_valid,
  input  logic [N-1:0]    i_src_l,
  input  logic [N-1:0]    i_src_r,
  output logic            o_src_ready,
  output logic [N-1:0]    o_data_l,
  output logic [N-1:0]    o_data_r,
  output logic            o_dval,
  input  logic [DBIT-1:0] i_disp,
  input  logic            i_disp_dval,
  output logic            o_busy,
  output logic            o_done,
  output logic [7:0]      o_frame_cnt,
  output logic [31:0]     o_out_cnt,
  output logic [31:0]     o_checksum
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [BW-1:0] r_blank;
  logic [7:0]    r_frame_cnt;
  logic [N-1:0]  r_data_l, r_data_r;
  logic          r_dval;

  logic       w_xfer, w_eol, w_eof, w_last_frame, w_start;
  logic [7:0] w_frame_inc;

  assign w_xfer       = (r_state == S_ACTIVE) && i_src_valid;
  assign w_eol        = w_xfer && (r_col == CW'(M - 1));
  assign w_eof        = w_eol && (r_row == RW'(ROWS - 1));
  assign w_frame_inc  = r_frame_cnt + 8'd1;
  assign w_last_frame = (i_nframes != 8'd0) && (w_frame_inc == i_nframes);
  assign w_start      = (r_state == S_IDLE) && i_start && !i_abort;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (w_eof) begin
          if (w_last_frame)        w_state_nxt = S_DONE;
          else if (i_vblank != '0) w_state_nxt = S_VBLANK;
        end else if (w_eol && (i_hblank != '0)) begin
          w_state_nxt = S_HBLANK;
        end
      end
      S_HBLANK, S_VBLANK: if (r_blank <= BW'(1)) w_state_nxt = S_ACTIVE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Blank length is latched at end of line so later input changes only affect the next blank
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_blank     <= '0;
      r_frame_cnt <= '0;
      r_data_l    <= '0;
      r_data_r    <= '0;
      r_dval      <= 1'b0;
    end else begin
      r_dval <= w_xfer && !i_abort;
      if (w_xfer) begin
        r_data_l <= i_src_l;
        r_data_r <= i_src_r;
      end
      if (w_start) begin
        r_col       <= '0;
        r_row       <= '0;
        r_frame_cnt <= '0;
      end else if (!i_abort) begin
        if (w_eol) begin
          r_col   <= '0;
          r_row   <= w_eof ? '0 : r_row + RW'(1);
          r_blank <= w_eof ? i_vblank : i_hblank;
          if (w_eof) r_frame_cnt <= w_frame_inc;
        end else if (w_xfer) begin
          r_col <= r_col + CW'(1);
        end else if ((r_state == S_HBLANK) || (r_state == S_VBLANK)) begin
          r_blank <= r_blank - BW'(1);
        end
      end
    end
  end

  assign o_src_ready = (r_state == S_ACTIVE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_data_l    = r_data_l;
  assign o_data_r    = r_data_r;
  assign o_dval      = r_dval;
  assign o_frame_cnt = r_frame_cnt;

  stereo_stream_capture #(
    .DBIT(DBIT)
  ) u_capture (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_start),
    .i_disp     (i_disp),
    .i_disp_dval(i_disp_dval),
    .o_out_cnt  (o_out_cnt),
    .o_checksum (o_checksum)
  );

endmodule
